serializer_scheduler: RTL

Round-robin scheduler that shares one N-bit parallel-to-serial datapath among R requesters. Each requester presents a parallel word with a request. The block grants one requester at a time, latches its word and shifts it out LSB-first with valid/last/source tags. An optional idle gap follows each word. It sits between the parallel producers and the single serial link.

---
 rtl/serial_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 19 +
 rtl/serializer_scheduler.sv | 85 ++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: shared state encoding and width helpers for the serializer scheduler
package serial_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int idx_w(input int v);
    return clog2(v) > 1 ? clog2(v) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin winner select starting at ptr
module rr_arbiter
  import serial_pkg::*;
#(
  parameter int R = 4
) (
  input  logic [R-1:0]        req,
  input  logic [idx_w(R)-1:0] ptr,
  output logic                any_req,
  output logic [idx_w(R)-1:0] win
);
  localparam int SW = idx_w(R);
  always_comb begin
    any_req = |req;
    win = '0;
    for (int i = R - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % R]) win = SW'((int'(ptr) + i) % R);
  end
endmodule

// File: rtl/serializer_scheduler.sv
// serializer_scheduler: round-robin shares one LSB-first serializer among R requesters
module serializer_scheduler
  import serial_pkg::*;
#(
  parameter int N   = 8,
  parameter int R   = 4,
  parameter int GAP = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [R-1:0]        req,
  input  logic [R*N-1:0]      data_in,
  output logic [R-1:0]        grant,
  output logic                busy,
  output logic                ser_out,
  output logic                ser_valid,
  output logic                ser_last,
  output logic [idx_w(R)-1:0] ser_src
);
  localparam int SW = idx_w(R);
  localparam int CW = clog2(N);
  localparam int GW = idx_w(GAP + 1);
  state_t state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d, src_q, src_d, win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] word_q, word_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [R-1:0] grant_q, grant_d;
  logic any_req, last, arb;
  rr_arbiter #(.R(R)) u_arb (.req(req), .ptr(ptr_q), .any_req(any_req), .win(win));
  assign last = state_q == S_SHIFT && cnt_q == CW'(N - 1);
  assign arb = state_q == S_IDLE || (last && GAP == 0);
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    src_d = src_q;
    cnt_d = cnt_q;
    word_d = word_q;
    gcnt_d = gcnt_q;
    grant_d = '0;
    if (arb && any_req) begin
      state_d = S_SHIFT;
      ptr_d = win == SW'(R - 1) ? '0 : win + SW'(1);
      src_d = win;
      cnt_d = '0;
      word_d = data_in[win*N +: N];
      grant_d = R'(1) << win;
    end else if (arb) begin
      state_d = S_IDLE;
    end else if (last) begin
      state_d = S_GAP;
      gcnt_d = GW'(GAP > 0 ? GAP - 1 : 0);
    end else if (state_q == S_SHIFT) begin
      cnt_d = cnt_q + CW'(1);
    end else if (state_q == S_GAP) begin
      state_d = gcnt_q == '0 ? S_IDLE : S_GAP;
      gcnt_d = gcnt_q == '0 ? gcnt_q : gcnt_q - GW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      src_q <= '0;
      cnt_q <= '0;
      word_q <= '0;
      gcnt_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      src_q <= src_d;
      cnt_q <= cnt_d;
      word_q <= word_d;
      gcnt_q <= gcnt_d;
      grant_q <= grant_d;
    end
  end
  assign grant = grant_q;
  assign busy = state_q != S_IDLE;
  assign ser_valid = state_q == S_SHIFT;
  assign ser_out = ser_valid & word_q[cnt_q];
  assign ser_last = last;
  assign ser_src = src_q;
endmodule
